// File: rtl/gelato_types.sv
// Shared types for the gelato warp fetch scheduler: warp indices, addresses,
// split-table entries, per-warp lifecycle state and the fetch request record.
package gelato_types;

  localparam int WARP_NUM = 8;
  localparam int WARP_W   = $clog2(WARP_NUM);
  localparam int ADDR_W   = 32;
  localparam int SPLIT_W  = 4;

  typedef logic [WARP_W-1:0]  warp_num_t;
  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [SPLIT_W-1:0] split_table_num_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READY    = 2'd1,
    INFLIGHT = 2'd2
  } warp_state_e;

  typedef struct packed {
    addr_t            pc;
    warp_num_t        warp_num;
    split_table_num_t split_table_num;
  } fetch_req_t;

endpackage

// File: rtl/gelato_rr_arbiter.sv
// N-way round-robin arbiter; the search starts at the pointer and the pointer
// moves just past the granted index whenever the caller takes the grant.
module gelato_rr_arbiter #(
  parameter  int N  = 8,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  input  logic [IW-1:0] granted_idx,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] cand;

  // Scan from the farthest offset back to the pointer so the nearest request wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = ptr_q + IW'(i);
      if (req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= granted_idx + IW'(1);
    end
  end

endmodule

// File: rtl/gelato_warp_scheduler.sv
// Per-warp fetch scheduler: tracks warp lifecycle/PC and issues one READY warp
// per cycle to I-Fetch. Define GELATO_SCHED_PERF_EN to add issue/stall counters.
module gelato_warp_scheduler
  import gelato_types::*;
#(
  parameter int WARP_NUM   = gelato_types::WARP_NUM,
  parameter int INIT_SPLIT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                launch_valid,
  input  warp_num_t           launch_warp_num,
  input  addr_t               launch_pc,
  input  split_table_num_t    launch_split_table_num,
  output logic                fetch_valid,
  input  logic                fetch_ready,
  output addr_t               fetch_pc,
  output warp_num_t           fetch_warp_num,
  output split_table_num_t    fetch_split_table_num,
  input  logic                resume_valid,
  input  warp_num_t           resume_warp_num,
  input  addr_t               resume_pc,
  input  split_table_num_t    resume_split_table_num,
  input  logic                finish_valid,
  input  warp_num_t           finish_warp_num,
  output logic [WARP_NUM-1:0] active_mask,
  output logic                busy
`ifdef GELATO_SCHED_PERF_EN
  ,
  output logic [31:0]         perf_issue_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  localparam int IW = $clog2(WARP_NUM);

  if ((WARP_NUM < 2) || ((WARP_NUM & (WARP_NUM - 1)) != 0)) begin : g_bad_warp_num
    $error("WARP_NUM must be a power of two and at least 2");
  end
  if ((INIT_SPLIT < 0) || (INIT_SPLIT >= (1 << SPLIT_W))) begin : g_bad_init_split
    $error("INIT_SPLIT does not fit in split_table_num_t");
  end

  warp_state_e      state_q [WARP_NUM];
  addr_t            pc_q    [WARP_NUM];
  split_table_num_t split_q [WARP_NUM];

  logic [WARP_NUM-1:0] ready_mask;
  logic                grant_valid;
  logic [IW-1:0]       grant_idx;
  logic                load;
  logic                fetch_valid_q;
  fetch_req_t          req_q;

  always_comb begin
    ready_mask  = '0;
    active_mask = '0;
    for (int w = 0; w < WARP_NUM; w++) begin
      ready_mask[w]  = (state_q[w] == READY);
      active_mask[w] = (state_q[w] != IDLE);
    end
  end

  // The output register refills whenever it is empty or being drained this cycle.
  assign load = grant_valid && (!fetch_valid_q || fetch_ready);

  gelato_rr_arbiter #(.N(WARP_NUM)) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (ready_mask),
    .advance     (load),
    .granted_idx (grant_idx),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Each warp only reacts to the event legal in its current state; finish beats resume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < WARP_NUM; w++) begin
        state_q[w] <= IDLE;
        pc_q[w]    <= '0;
        split_q[w] <= '0;
      end
    end else begin
      for (int w = 0; w < WARP_NUM; w++) begin
        case (state_q[w])
          IDLE: begin
            if (launch_valid && (launch_warp_num == warp_num_t'(w))) begin
              state_q[w] <= READY;
              pc_q[w]    <= launch_pc;
              split_q[w] <= launch_split_table_num;
            end
          end
          READY: begin
            if (load && (grant_idx == IW'(w))) begin
              state_q[w] <= INFLIGHT;
            end
          end
          INFLIGHT: begin
            if (finish_valid && (finish_warp_num == warp_num_t'(w))) begin
              state_q[w] <= IDLE;
            end else if (resume_valid && (resume_warp_num == warp_num_t'(w))) begin
              state_q[w] <= READY;
              pc_q[w]    <= resume_pc;
              split_q[w] <= resume_split_table_num;
            end
          end
          default: state_q[w] <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid_q <= 1'b0;
      req_q         <= '0;
    end else if (load) begin
      fetch_valid_q         <= 1'b1;
      req_q.pc              <= pc_q[grant_idx];
      req_q.warp_num        <= warp_num_t'(grant_idx);
      req_q.split_table_num <= split_q[grant_idx];
    end else if (fetch_valid_q && fetch_ready) begin
      fetch_valid_q <= 1'b0;
    end
  end

  assign fetch_valid           = fetch_valid_q;
  assign fetch_pc              = req_q.pc;
  assign fetch_warp_num        = req_q.warp_num;
  assign fetch_split_table_num = req_q.split_table_num;
  assign busy                  = (|active_mask) || fetch_valid_q;

`ifdef GELATO_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (fetch_valid_q && fetch_ready && (perf_issue_cnt != '1)) begin
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      end
      if (fetch_valid_q && !fetch_ready && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gelato_warp_scheduler.sv
// Bench for gelato_warp_scheduler: directed table, corner-case sequences and
// random traffic against a behavioural model of the warp lifecycle.
module tb_gelato_warp_scheduler;
  import gelato_types::*;

  localparam int NW = 8;
  localparam int M_IDLE = 0, M_READY = 1, M_INFLIGHT = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             launch_valid = 1'b0;
  warp_num_t        launch_warp_num = '0;
  addr_t            launch_pc = '0;
  split_table_num_t launch_split_table_num = '0;
  logic             fetch_valid;
  logic             fetch_ready = 1'b0;
  addr_t            fetch_pc;
  warp_num_t        fetch_warp_num;
  split_table_num_t fetch_split_table_num;
  logic             resume_valid = 1'b0;
  warp_num_t        resume_warp_num = '0;
  addr_t            resume_pc = '0;
  split_table_num_t resume_split_table_num = '0;
  logic             finish_valid = 1'b0;
  warp_num_t        finish_warp_num = '0;
  logic [NW-1:0]    active_mask;
  logic             busy;
`ifdef GELATO_SCHED_PERF_EN
  logic [31:0]      perf_issue_cnt;
  logic [31:0]      perf_stall_cnt;
`endif

  gelato_warp_scheduler #(.WARP_NUM(NW)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .launch_valid           (launch_valid),
    .launch_warp_num        (launch_warp_num),
    .launch_pc              (launch_pc),
    .launch_split_table_num (launch_split_table_num),
    .fetch_valid            (fetch_valid),
    .fetch_ready            (fetch_ready),
    .fetch_pc               (fetch_pc),
    .fetch_warp_num         (fetch_warp_num),
    .fetch_split_table_num  (fetch_split_table_num),
    .resume_valid           (resume_valid),
    .resume_warp_num        (resume_warp_num),
    .resume_pc              (resume_pc),
    .resume_split_table_num (resume_split_table_num),
    .finish_valid           (finish_valid),
    .finish_warp_num        (finish_warp_num),
    .active_mask            (active_mask),
    .busy                   (busy)
`ifdef GELATO_SCHED_PERF_EN
    ,
    .perf_issue_cnt         (perf_issue_cnt),
    .perf_stall_cnt         (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit lv; int lw; int unsigned lpc; int ls;
    bit rv; int rw; int unsigned rpc; int rs;
    bit fnv; int fnw;
    bit rdy;
  } stim_t;

  typedef struct {
    stim_t       s;
    bit          exp_fv;
    int          exp_w;
    int unsigned exp_pc;
    int          exp_split;
    int          exp_mask;
    bit          exp_busy;
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: warp lifecycle as plain arrays, a rotating start index and an output slot.
  int          m_st  [NW];
  int unsigned m_pc  [NW];
  int          m_sp  [NW];
  int          m_ptr;
  bit          m_fv;
  int unsigned m_fpc;
  int          m_fw;
  int          m_fs;
  int unsigned m_issue;
  int unsigned m_stall;

  function automatic stim_t st(bit lv, int lw, int unsigned lpc, int ls,
                               bit rv, int rw, int unsigned rpc, int rs,
                               bit fnv, int fnw, bit rdy);
    stim_t r;
    r.lv = lv; r.lw = lw; r.lpc = lpc; r.ls = ls;
    r.rv = rv; r.rw = rw; r.rpc = rpc; r.rs = rs;
    r.fnv = fnv; r.fnw = fnw; r.rdy = rdy;
    return r;
  endfunction

  function automatic stim_t idle(bit rdy);
    return st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endfunction

  task automatic modelReset();
    for (int w = 0; w < NW; w++) begin
      m_st[w] = M_IDLE; m_pc[w] = 0; m_sp[w] = 0;
    end
    m_ptr = 0; m_fv = 0; m_fpc = 0; m_fw = 0; m_fs = 0;
    m_issue = 0; m_stall = 0;
  endtask

  task automatic modelStep(input stim_t s);
    int old [NW];
    int pick;
    old = m_st;
    if (m_fv && s.rdy && m_issue != 32'hFFFF_FFFF) m_issue++;
    if (m_fv && !s.rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
    pick = -1;
    for (int k = 0; k < NW; k++) begin
      if (pick < 0 && old[(m_ptr + k) % NW] == M_READY) pick = (m_ptr + k) % NW;
    end
    if (pick >= 0 && (!m_fv || s.rdy)) begin
      m_fv = 1; m_fpc = m_pc[pick]; m_fw = pick; m_fs = m_sp[pick];
      m_st[pick] = M_INFLIGHT;
      m_ptr = (pick + 1) % NW;
    end else if (m_fv && s.rdy) begin
      m_fv = 0;
    end
    if (s.lv && old[s.lw] == M_IDLE) begin
      m_st[s.lw] = M_READY; m_pc[s.lw] = s.lpc; m_sp[s.lw] = s.ls;
    end
    if (s.fnv && old[s.fnw] == M_INFLIGHT) m_st[s.fnw] = M_IDLE;
    if (s.rv && old[s.rw] == M_INFLIGHT && !(s.fnv && s.fnw == s.rw)) begin
      m_st[s.rw] = M_READY; m_pc[s.rw] = s.rpc; m_sp[s.rw] = s.rs;
    end
  endtask

  function automatic int modelMask();
    int m = 0;
    for (int w = 0; w < NW; w++) if (m_st[w] != M_IDLE) m |= (1 << w);
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    launch_valid           = s.lv;
    launch_warp_num        = warp_num_t'(s.lw);
    launch_pc              = addr_t'(s.lpc);
    launch_split_table_num = split_table_num_t'(s.ls);
    resume_valid           = s.rv;
    resume_warp_num        = warp_num_t'(s.rw);
    resume_pc              = addr_t'(s.rpc);
    resume_split_table_num = split_table_num_t'(s.rs);
    finish_valid           = s.fnv;
    finish_warp_num        = warp_num_t'(s.fnw);
    fetch_ready            = s.rdy;
    @(posedge clk);
    modelStep(s);
    #1;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(m_fv));
    if (m_fv) begin
      checkOutput({tag, ".fetch_pc"}, fetch_pc, m_fpc);
      checkOutput({tag, ".fetch_warp"}, 32'(fetch_warp_num), 32'(m_fw));
      checkOutput({tag, ".fetch_split"}, 32'(fetch_split_table_num), 32'(m_fs));
    end
    checkOutput({tag, ".active_mask"}, 32'(active_mask), 32'(modelMask()));
    checkOutput({tag, ".busy"}, 32'(busy), 32'((modelMask() != 0) || m_fv));
`ifdef GELATO_SCHED_PERF_EN
    checkOutput({tag, ".perf_issue"}, perf_issue_cnt, m_issue);
    checkOutput({tag, ".perf_stall"}, perf_stall_cnt, m_stall);
`endif
  endtask

  // Asserted mid-cycle so the asynchronous clear is observed before any edge.
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("reset.fetch_valid", 32'(fetch_valid), 32'd0);
    checkOutput("reset.fetch_pc", fetch_pc, 32'd0);
    checkOutput("reset.active_mask", 32'(active_mask), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
`ifdef GELATO_SCHED_PERF_EN
    checkOutput("reset.perf_issue", perf_issue_cnt, 32'd0);
    checkOutput("reset.perf_stall", perf_stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{st(1, 3, 'h1000, 2, 0, 0, 0, 0, 0, 0, 1), 0, 0, 0, 0, 'h08, 1};
    tbl[1]  = '{idle(1),                                   1, 3, 'h1000, 2, 'h08, 1};
    tbl[2]  = '{idle(1),                                   0, 0, 0, 0, 'h08, 1};
    tbl[3]  = '{idle(1),                                   0, 0, 0, 0, 'h08, 1};
    tbl[4]  = '{st(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1),       0, 0, 0, 0, 'h00, 0};
    tbl[5]  = '{st(1, 0, 'h40, 1, 0, 0, 0, 0, 0, 0, 1),    0, 0, 0, 0, 'h01, 1};
    tbl[6]  = '{st(1, 1, 'h44, 1, 0, 0, 0, 0, 0, 0, 1),    1, 0, 'h40, 1, 'h03, 1};
    tbl[7]  = '{st(1, 2, 'h48, 1, 1, 0, 'h100, 3, 0, 0, 1), 1, 1, 'h44, 1, 'h07, 1};
    tbl[8]  = '{st(0, 0, 0, 0, 1, 1, 'h104, 3, 0, 0, 1),   1, 2, 'h48, 1, 'h07, 1};
    tbl[9]  = '{st(0, 0, 0, 0, 1, 2, 'h108, 3, 0, 0, 1),   1, 0, 'h100, 3, 'h07, 1};
    tbl[10] = '{st(0, 0, 0, 0, 1, 0, 'h200, 3, 0, 0, 1),   1, 1, 'h104, 3, 'h07, 1};
    tbl[11] = '{st(0, 0, 0, 0, 1, 1, 'h204, 3, 0, 0, 1),   1, 2, 'h108, 3, 'h07, 1};

    modelReset();
    #2;
    doReset();

    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].s);
      checkOutput($sformatf("tbl%0d.fetch_valid", i), 32'(fetch_valid), 32'(tbl[i].exp_fv));
      if (tbl[i].exp_fv) begin
        checkOutput($sformatf("tbl%0d.fetch_warp", i), 32'(fetch_warp_num), 32'(tbl[i].exp_w));
        checkOutput($sformatf("tbl%0d.fetch_pc", i), fetch_pc, tbl[i].exp_pc);
        checkOutput($sformatf("tbl%0d.fetch_split", i), 32'(fetch_split_table_num), 32'(tbl[i].exp_split));
      end
      checkOutput($sformatf("tbl%0d.active_mask", i), 32'(active_mask), 32'(tbl[i].exp_mask));
      checkOutput($sformatf("tbl%0d.busy", i), 32'(busy), 32'(tbl[i].exp_busy));
    end

    // Backpressure: warp 5 stays frozen on the port while warp 6 waits.
    doReset();
    applyStimulus(st(1, 5, 'h500, 5, 0, 0, 0, 0, 0, 0, 0));
    checkOutput("stall.pre_valid", 32'(fetch_valid), 32'd0);
    applyStimulus(st(1, 6, 'h600, 6, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(idle(0));
      checkOutput($sformatf("stall%0d.fetch_warp", i), 32'(fetch_warp_num), 32'd5);
      checkOutput($sformatf("stall%0d.fetch_pc", i), fetch_pc, 32'h500);
      checkOutput($sformatf("stall%0d.fetch_valid", i), 32'(fetch_valid), 32'd1);
    end
    applyStimulus(idle(1));
    checkOutput("stall.next_warp", 32'(fetch_warp_num), 32'd6);
    checkOutput("stall.next_pc", fetch_pc, 32'h600);
`ifdef GELATO_SCHED_PERF_EN
    checkOutput("stall.perf_stall", perf_stall_cnt, 32'd4);
    checkOutput("stall.perf_issue", perf_issue_cnt, 32'd1);
`endif

    // Resume and finish of the same warp in one cycle retire it.
    doReset();
    applyStimulus(st(1, 1, 'h700, 0, 0, 0, 0, 0, 0, 0, 1));
    applyStimulus(idle(1));
    checkOutput("fin.issued_warp", 32'(fetch_warp_num), 32'd1);
    applyStimulus(st(0, 0, 0, 0, 1, 1, 'h2000, 0, 1, 1, 1));
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("fin%0d.fetch_valid", i), 32'(fetch_valid), 32'd0);
      checkOutput($sformatf("fin%0d.active_mask", i), 32'(active_mask), 32'd0);
      checkOutput($sformatf("fin%0d.busy", i), 32'(busy), 32'd0);
      applyStimulus(idle(1));
    end

    // Launch of a READY warp and resume of an IDLE warp are both ignored.
    doReset();
    applyStimulus(st(1, 4, 'h3000, 1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(st(1, 4, 'h3100, 2, 1, 7, 'h7000, 0, 0, 0, 0));
    checkOutput("ign.fetch_pc", fetch_pc, 32'h3000);
    checkOutput("ign.fetch_split", 32'(fetch_split_table_num), 32'd1);
    checkOutput("ign.active_mask", 32'(active_mask), 32'h10);
    applyStimulus(idle(1));
    checkOutput("ign.drained_valid", 32'(fetch_valid), 32'd0);
    checkOutput("ign.drained_mask", 32'(active_mask), 32'h10);

    // Reset with a request pending on the port.
    applyStimulus(st(1, 2, 'h900, 0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(idle(0));
    checkOutput("rstpend.fetch_valid", 32'(fetch_valid), 32'd1);
    doReset();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      stim_t s;
      int inflight [$];
      for (int w = 0; w < NW; w++) if (m_st[w] == M_INFLIGHT) inflight.push_back(w);
      s = st(($urandom % 3) == 0, int'($urandom % NW), $urandom & 32'hFFFF_FFFC, int'($urandom % 16),
             ($urandom % 2) == 0, int'($urandom % NW), $urandom & 32'hFFFF_FFFC, int'($urandom % 16),
             ($urandom % 7) == 0, int'($urandom % NW), ($urandom % 10) < 7);
      if (inflight.size() > 0 && ($urandom % 4) != 0) s.rw = inflight[$urandom % inflight.size()];
      if (inflight.size() > 0 && ($urandom % 2) == 0) s.fnw = inflight[$urandom % inflight.size()];
      if (($urandom % 8) == 0) s.fnw = s.rw;
      applyStimulus(s);
      checkModel($sformatf("rnd%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/gelato_warp_scheduler.md
Name: gelato_warp_scheduler

Overview:
- Per-warp fetch scheduler that sits in front of the I-Fetch stage and decides which warp fetches next.
- Tracks the lifecycle state and next PC of every warp, and picks one READY warp per cycle with round-robin fairness.
- Presents the pick on a registered valid/ready fetch-request port; I-Fetch consumes it and later drives the I-Fetch -> I-Decode handoff.
- Decode/branch logic returns warps via resume or finish.

Parameters:
- WARP_NUM, 8: number of hardware warps; power of two, ≥2.
- INIT_SPLIT, 0: split_table_num loaded when a warp is launched without one (reserved; launch always supplies one).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- launch_valid  in  1  start a warp
- launch_warp_num  in  warp_num_t  warp to start
- launch_pc  in  addr_t  start PC
- launch_split_table_num  in  split_table_num_t  initial split-table entry
- fetch_valid  out  1  fetch request valid
- fetch_ready  in  1  I-Fetch accepts request
- fetch_pc  out  addr_t  PC to fetch
- fetch_warp_num  out  warp_num_t  warp of request
- fetch_split_table_num  out  split_table_num_t  split entry of request
- resume_valid  in  1  in-flight warp may fetch again
- resume_warp_num  in  warp_num_t
- resume_pc  in  addr_t  next PC
- resume_split_table_num  in  split_table_num_t
- finish_valid  in  1  warp exited
- finish_warp_num  in  warp_num_t
- active_mask  out  WARP_NUM  bit w = warp w not IDLE
- busy  out  1  any warp not IDLE, or fetch_valid

Behaviour:
- Reset: async on rst_n low.
  - All warps IDLE; pc/split regs 0; rr pointer 0.
  - fetch_valid=0, fetch_pc/warp_num/split=0, active_mask=0, busy=0.
  - Reset mid-operation discards any pending request with no handshake.
- Per-warp state (warp_state_e): IDLE, READY, INFLIGHT.
  - IDLE→READY on launch; pc and split are loaded. Launch of a non-IDLE warp is ignored.
  - READY→INFLIGHT when the warp is loaded into the output register. This is the selection moment, not the handshake.
  - INFLIGHT→READY on resume; pc and split are loaded. Resume of a non-INFLIGHT warp is ignored.
  - INFLIGHT→IDLE on finish. Finish of a non-INFLIGHT warp is ignored.
  - Resume and finish on the same warp in the same cycle: finish wins.
  - Launch/resume/finish on different warps in the same cycle are all applied.
- Output register:
  - Loads when empty (!fetch_valid) or draining (fetch_valid && fetch_ready) and at least one warp is READY.
  - Otherwise fetch_valid deasserts after a drain.
  - While fetch_valid=1 && fetch_ready=0, all fetch_* outputs hold stable.
  - Back-to-back issue at 1 request/cycle when fetch_ready is held high and warps are READY.
- Arbitration:
  - Round-robin over READY warps, starting from the rr pointer with wrap at WARP_NUM-1 → 0.
  - On load of warp w, the pointer becomes (w+1) mod WARP_NUM.
  - A warp made READY in cycle n is not visible to the arbiter until cycle n+1, so there is no same-cycle bypass.
- Latency: launch sampled at edge n → fetch_valid high after edge n+1 (minimum 2 cycles launch-to-request).
- active_mask and busy are combinational from state/registers.
- warp_num_t arithmetic wraps naturally at WARP_NUM.

Optional Feature:
- GELATO_SCHED_PERF_EN defined:
  - Adds outputs perf_issue_cnt (32b, increments on each fetch handshake) and perf_stall_cnt (32b, increments each cycle fetch_valid && !fetch_ready).
  - Both counters are reset to 0 and saturate at all-ones.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- gelato_types gains:
  - warp_state_e (2-bit enum IDLE/READY/INFLIGHT)
  - WARP_NUM constant
  - fetch_req_t struct {pc, warp_num, split_table_num}
  - warp_num_t, addr_t and split_table_num_t are reused.
- Sub-module gelato_rr_arbiter:
  - Parameterized N-way round-robin.
  - Inputs: req mask, advance, granted index.
  - Outputs: grant_valid, grant_idx.
  - Owns the pointer register.

Test Plan:
- Launch warp 3 pc=0x1000 split=2, fetch_ready=1 → fetch_valid on cycle 2 with pc=0x1000 warp=3 split=2; active_mask=0x08; no second request until resume.
- Launch warps 0,1,2 together, fetch_ready=1, resume each immediately after issue → grant order 0,1,2,0,1,2, one request per cycle after fill.
- Warp 5 issued, fetch_ready=0 for 4 cycles while warp 6 launched → outputs frozen at warp 5 for 4 cycles; warp 6 issued the cycle after ready rises.
- Warp 1 INFLIGHT, same-cycle resume(pc=0x2000)+finish → warp 1 IDLE, no further request, active_mask bit1=0, busy=0 if no other warps.
- Launch of already-READY warp 4 with pc=0x3000 → ignored, original pc issued; resume of IDLE warp 7 → ignored.
- rst_n low while fetch_valid=1 → fetch_valid=0 and active_mask=0 immediately (asynchronous); with GELATO_SCHED_PERF_EN, counters read 0.
